// File: rtl/switch_pkg.sv
// Shared types and sizing helpers for the switch input bank.
package switch_pkg;

    localparam int MAX_CH_W = 4;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_CH_W-1:0] channel;
        logic                rising;
    } event_t;

endpackage

// File: rtl/switch_input_bank_if.sv
// Event handshake between the switch bank and its consumer.
interface switch_input_bank_if
    import switch_pkg::*;
#(
    parameter int CW = ch_width(4)
);

    logic          eventValid;
    logic          eventReady;
    logic [CW-1:0] eventChannel;
    logic          eventRising;

    modport master (
        output eventValid,
        output eventChannel,
        output eventRising,
        input  eventReady
    );

    modport slave (
        input  eventValid,
        input  eventChannel,
        input  eventRising,
        output eventReady
    );

endinterface

// File: rtl/switch_channel.sv
// One switch: synchroniser, debounce counter and toggle flop.
module switch_channel
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2,
    parameter bit TOGGLE          = 1'b0
) (
    input  logic clock,
    input  logic isReset,
    input  logic raw,
    output logic state,
    output logic change,
    output logic rise
);

    localparam int CNTW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNTW-1:0] LAST = CNTW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNTW-1:0]        cnt;
    logic                   level;
    logic                   tog;
    logic                   sync_in;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign change  = (sync_in != level) && (cnt == LAST);
    assign rise    = sync_in;
    assign state   = TOGGLE ? tog : level;

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            tog    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync_in == level) begin
                cnt <= '0;
            end else if (change) begin
                level <= sync_in;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // toggle only on debounced presses, never on releases
            if (change && sync_in) begin
                tog <= ~tog;
            end
        end
    end

endmodule

// File: rtl/switch_input_bank.sv
// Debounced switch bank with per-channel pending flags and a
// lowest-index-first event register behind a valid/ready handshake.
module switch_input_bank
    import switch_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter int                  SYNC_STAGES     = 2,
    parameter logic [CHANNELS-1:0] TOGGLE_MASK     = '0
) (
    input  logic                clock,
    input  logic                isReset,
    input  logic [CHANNELS-1:0] switch,
    input  logic                clearOverflow,
    output logic [CHANNELS-1:0] switchState,
    output logic [CHANNELS-1:0] overflow,
    switch_input_bank_if.master evt
);

    localparam int CW = ch_width(CHANNELS);

    logic [CHANNELS-1:0] change;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] pdir;
    logic [CHANNELS-1:0] take;
    logic [MAX_CH_W-1:0] sel;
    logic                sel_rise;
    logic                found;
    logic                load;
    logic                ev_valid;
    event_t              ev;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        switch_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .TOGGLE          (TOGGLE_MASK[i])
        ) u_ch (
            .clock   (clock),
            .isReset (isReset),
            .raw     (switch[i]),
            .state   (switchState[i]),
            .change  (change[i]),
            .rise    (rise[i])
        );
    end

    assign load = !ev_valid || evt.eventReady;

    // scan downward so the lowest pending index wins
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        sel_rise = 1'b0;
        take     = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                found    = 1'b1;
                sel      = MAX_CH_W'(i);
                sel_rise = pdir[i];
                take     = '0;
                take[i]  = load;
            end
        end
    end

    always_ff @(posedge clock or posedge isReset) begin
        if (isReset) begin
            pend     <= '0;
            pdir     <= '0;
            overflow <= '0;
            ev_valid <= 1'b0;
            ev       <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (change[i]) begin
                    pend[i] <= 1'b1;
                    pdir[i] <= rise[i];
                end else if (take[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            // a change racing its own load re-arms without loss
            overflow <= (clearOverflow ? '0 : overflow)
                      | (change & pend & ~take);
            if (load) begin
                ev_valid <= found;
                if (found) begin
                    ev.channel <= sel;
                    ev.rising  <= sel_rise;
                end
            end
        end
    end

    assign evt.eventValid   = ev_valid;
    assign evt.eventChannel = ev.channel[CW-1:0];
    assign evt.eventRising  = ev.rising;

    wire unused_ch = &{1'b0, ev.channel};

endmodule

// File: tb/tb_switch_input_bank.sv
// Directed and randomized checks of switch_input_bank against a
// window-based debounce model and a pending/event scoreboard.
module tb_switch_input_bank;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int SS = 2;
    localparam logic [3:0] TM = 4'b0100;

    logic       clock = 1'b0;
    logic       isReset;
    logic       clearOverflow;
    logic [3:0] switch;
    logic [3:0] switchState;
    logic [3:0] overflow;

    switch_input_bank_if #(.CW(2)) evt();

    switch_input_bank #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .TOGGLE_MASK     (TM)
    ) dut (
        .clock         (clock),
        .isReset       (isReset),
        .switch        (switch),
        .clearOverflow (clearOverflow),
        .switchState   (switchState),
        .overflow      (overflow),
        .evt           (evt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cycno  = 0;

    // model state
    bit samp [CH][SS+DB];
    bit [3:0] m_lvl, m_tog, m_pend, m_pdir, m_ovf;
    bit m_evv, m_evr;
    int m_evc;

    typedef struct {
        int cyc;
        int ch;
        bit r;
    } ev_rec_t;
    ev_rec_t evlog[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < CH; i++)
            for (int k = 0; k < SS + DB; k++) samp[i][k] = 1'b0;
        m_lvl = '0; m_tog = '0; m_pend = '0; m_pdir = '0; m_ovf = '0;
        m_evv = 1'b0; m_evr = 1'b0; m_evc = 0;
    endtask

    function automatic logic [3:0] exp_state();
        logic [3:0] r;
        for (int i = 0; i < CH; i++) r[i] = TM[i] ? m_tog[i] : m_lvl[i];
        return r;
    endfunction

    // Level follows the synchronised input once it has been stable
    // and different for DB consecutive samples.
    task automatic m_step();
        bit [3:0] flip, fdir, take;
        bit load, found, same;
        int sel;
        for (int i = 0; i < CH; i++) begin
            for (int k = SS + DB - 1; k > 0; k--) samp[i][k] = samp[i][k-1];
            samp[i][0] = switch[i];
            same = 1'b1;
            for (int k = SS; k < SS + DB; k++)
                if (samp[i][k] != samp[i][SS]) same = 1'b0;
            flip[i] = same && (samp[i][SS] != m_lvl[i]);
            fdir[i] = samp[i][SS];
        end
        load  = !m_evv || evt.eventReady;
        found = 1'b0;
        sel   = 0;
        for (int i = CH - 1; i >= 0; i--)
            if (m_pend[i]) begin found = 1'b1; sel = i; end
        take = '0;
        if (load && found) take[sel] = 1'b1;
        m_ovf = (clearOverflow ? 4'b0 : m_ovf) | (flip & m_pend & ~take);
        if (load) begin
            m_evv = found;
            if (found) begin m_evc = sel; m_evr = m_pdir[sel]; end
        end
        for (int i = 0; i < CH; i++) begin
            if (flip[i]) begin
                m_pend[i] = 1'b1;
                m_pdir[i] = fdir[i];
                m_lvl[i]  = fdir[i];
                if (fdir[i]) m_tog[i] = ~m_tog[i];
            end else if (take[i]) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("switchState", 32'(switchState), 32'(exp_state()));
        chk("eventValid", 32'(evt.eventValid), 32'(m_evv));
        chk("eventChannel", 32'(evt.eventChannel), 32'(m_evc));
        chk("eventRising", 32'(evt.eventRising), 32'(m_evr));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cyc();
        bit hs, hr;
        int hch;
        hs  = evt.eventValid && evt.eventReady;
        hch = int'(evt.eventChannel);
        hr  = evt.eventRising;
        @(posedge clock);
        if (!isReset) m_step();
        cycno++;
        if (hs && !isReset) evlog.push_back('{cycno, hch, hr});
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        int c0, c1, g, bad;
        logic [3:0] dirs;
        isReset = 1'b1;
        switch = '0;
        clearOverflow = 1'b0;
        evt.eventReady = 1'b1;
        m_reset();
        repeat (2) @(negedge clock);
        compare_all();
        chk("reset_state", 32'({switchState, overflow, evt.eventValid}), 32'd0);
        isReset = 1'b0;
        cyc();

        // clean step on channel 0
        evlog.delete();
        switch[0] = 1'b1;
        repeat (5) cyc();
        chk("step_early", 32'(switchState[0]), 32'd0);
        cyc();
        chk("step_level", 32'(switchState[0]), 32'd1);
        cyc();
        chk("step_event", 32'({evt.eventValid, evt.eventChannel,
                               evt.eventRising}), 32'b1001);
        cyc();
        chk("step_pulse", 32'(evt.eventValid), 32'd0);

        // glitch on channel 1
        evlog.delete();
        switch[1] = 1'b1;
        repeat (3) cyc();
        switch[1] = 1'b0;
        repeat (12) cyc();
        chk("glitch_state", 32'(switchState[1]), 32'd0);
        chk("glitch_events", 32'(evlog.size()), 32'd0);

        // toggle mode on channel 2
        evlog.delete();
        for (int p = 0; p < 2; p++) begin
            switch[2] = 1'b1;
            repeat (10) cyc();
            chk("toggle_press", 32'(switchState[2]), (p == 0) ? 32'd1 : 32'd0);
            switch[2] = 1'b0;
            repeat (10) cyc();
            chk("toggle_rel", 32'(switchState[2]), (p == 0) ? 32'd1 : 32'd0);
        end
        chk("toggle_count", 32'(evlog.size()), 32'd4);
        dirs = '0;
        bad = 0;
        for (int j = 0; j < evlog.size() && j < 4; j++) begin
            dirs[j] = evlog[j].r;
            if (evlog[j].ch != 2) bad++;
        end
        chk("toggle_dirs", 32'(dirs), 32'b0101);
        chk("toggle_chan", 32'(bad), 32'd0);

        // simultaneous steps on channels 1 and 3
        evt.eventReady = 1'b0;
        switch[1] = 1'b1;
        switch[3] = 1'b1;
        repeat (10) cyc();
        evlog.delete();
        evt.eventReady = 1'b1;
        repeat (3) cyc();
        c0 = (evlog.size() > 0) ? evlog[0].ch : -1;
        c1 = (evlog.size() > 1) ? evlog[1].ch : -1;
        g  = (evlog.size() > 1) ? evlog[1].cyc - evlog[0].cyc : -1;
        chk("simul_first", 32'(c0), 32'd1);
        chk("simul_second", 32'(c1), 32'd3);
        chk("simul_gap", 32'(g), 32'd1);

        // overflow on channel 0
        evt.eventReady = 1'b0;
        switch[0] = 1'b0;
        repeat (8) cyc();
        switch[0] = 1'b1;
        repeat (8) cyc();
        switch[0] = 1'b0;
        repeat (8) cyc();
        chk("ovf_set", 32'(overflow), 32'b0001);
        clearOverflow = 1'b1;
        cyc();
        clearOverflow = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        evt.eventReady = 1'b1;
        repeat (6) cyc();

        // reset two cycles into a debounce
        switch[0] = 1'b1;
        repeat (2) cyc();
        isReset = 1'b1;
        m_reset();
        #1;
        chk("reset_async", 32'({switchState, overflow, evt.eventValid,
                                evt.eventChannel, evt.eventRising}), 32'd0);
        switch = '0;
        cyc();
        isReset = 1'b0;
        evlog.delete();
        repeat (15) cyc();
        chk("reset_no_event", 32'(evlog.size()), 32'd0);

        // switch held high through reset
        isReset = 1'b1;
        m_reset();
        switch = 4'b1000;
        cyc();
        isReset = 1'b0;
        repeat (5) cyc();
        chk("held_early", 32'(switchState[3]), 32'd0);
        cyc();
        chk("held_level", 32'(switchState[3]), 32'd1);
        cyc();
        chk("held_event", 32'({evt.eventValid, evt.eventChannel,
                               evt.eventRising}), 32'b1111);

        // randomized traffic
        repeat (1500) begin
            cyc();
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 9) == 0) switch[i] = ~switch[i];
            evt.eventReady = ($urandom_range(0, 3) != 0);
            clearOverflow = ($urandom_range(0, 15) == 0);
            if (isReset) begin
                isReset = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                isReset = 1'b1;
                m_reset();
            end
        end
        isReset = 1'b0;
        clearOverflow = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
